// File: rtl/riot_arbiter.sv
// riot_arbiter: shares one 6532 RIOT bus between a CPU-side requester (0) and
// a debug/DMA-side requester (1) with round-robin arbitration. Every access
// runs IDLE -> SETUP -> ACCESS (1+WAIT_STATES cycles) -> DONE. All RIOT pins
// are registered, so REQ never reaches them combinationally.
//
// Handshake: a requester raises REQx with WEx/ADDRx/WDATAx stable and keeps
// them until ACKx. ACKx is a one-cycle pulse in DONE, and RDATA is valid in
// that same cycle. Fields are latched at grant, so later changes are ignored.
// A REQx still high in the IDLE after DONE is taken as a new request.
module riot_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [7:0] ADDR0,
    input  logic [7:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic [1:0] RIOT_CS,
    output logic       RIOT_RS_N,
    output logic [6:0] RIOT_A,
    output logic       RIOT_RW,
    output logic [7:0] RIOT_DIN,
    input  logic [7:0] RIOT_DOUT,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // {CS2_N, CS1}: only CS_ON actually selects the chip.
    localparam logic [1:0] CS_ON  = 2'b01;
    localparam logic [1:0] CS_OFF = 2'b10;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       we_q;
    logic [3:0] wcnt;

    logic       pick;
    logic       pick_we;
    logic [7:0] pick_addr;
    logic [7:0] pick_wdata;

    assign DBG_STATE = state;

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        pick = REQ1;
        if (REQ0 && REQ1) begin
            pick = ~last_grant;
        end
        pick_we    = pick ? WE1    : WE0;
        pick_addr  = pick ? ADDR1  : ADDR0;
        pick_wdata = pick ? WDATA1 : WDATA0;
    end

    // Access sequencer; bus registers keep their values after DONE.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            we_q       <= 1'b0;
            wcnt       <= 4'd0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            RDATA      <= 8'h00;
            BUSY       <= 1'b0;
            RIOT_CS    <= CS_OFF;
            RIOT_RS_N  <= 1'b1;
            RIOT_A     <= 7'd0;
            RIOT_RW    <= 1'b1;
            RIOT_DIN   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        we_q       <= pick_we;
                        RIOT_RS_N  <= pick_addr[7];
                        RIOT_A     <= pick_addr[6:0];
                        RIOT_DIN   <= pick_wdata;
                        RIOT_RW    <= ~pick_we;
                        BUSY       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    wcnt    <= WS;
                    RIOT_CS <= CS_ON;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (wcnt == 4'd0) begin
                        // This edge commits a write on the RIOT side or samples read data.
                        if (!we_q) begin
                            RDATA <= RIOT_DOUT;
                        end
                        RIOT_CS <= CS_OFF;
                        RIOT_RW <= 1'b1;
                        ACK0    <= ~grant;
                        ACK1    <= grant;
                        state   <= DONE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                DONE: begin
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/riot_arbiter.md
# riot_arbiter

Two-requester access controller for the 6532 RIOT. It shares the single RIOT bus between requester 0 (CPU side) and requester 1 (debug/DMA side), using round-robin arbitration. Each access is sequenced through a SETUP, ACCESS and DONE handshake, and read data is captured for the granted requester. The block sits between the requesters and the RIOT's CS/RS_N/A/R_W/D_IN/D_OUT pins. The RIOT's IRQ_N and PA/PB ports are not touched.

## Interface
Parameters:
- WAIT_STATES, 0: extra ACCESS cycles inserted per access (0..15).

Ports:
- CLK  in  1  single clock, shared with the RIOT.
- RES_N  in  1  reset; asynchronous, active-low.
- REQ0, REQ1  in  1  access request; held high with fields stable until the matching ACK.
- WE0, WE1  in  1  1 = write, 0 = read.
- ADDR0, ADDR1  in  8  bit7 = 0 selects RAM, 1 selects I/O/timer; bits 6:0 are the RIOT address.
- WDATA0, WDATA1  in  8  write data.
- ACK0, ACK1  out  1  one-cycle completion pulse.
- RDATA  out  8  captured read data; valid when ACKx is high.
- BUSY  out  1  high in every state except IDLE.
- RIOT_CS  out  2  {CS2_N, CS1}; 2'b01 selects the RIOT, 2'b10 deselects it.
- RIOT_RS_N  out  1  RAM select, equal to ADDR[7].
- RIOT_A  out  7  RIOT address.
- RIOT_RW  out  1  0 = write, 1 = read.
- RIOT_DIN  out  8  data to the RIOT.
- RIOT_DOUT  in  8  data from the RIOT (combinational on its side).

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any REQ is high, grant one requester, latch its WE/ADDR/WDATA into the bus registers, and go to SETUP.
  - If no REQ is high, stay in IDLE.
- Arbitration:
  - A single requester is granted unconditionally.
  - When both request, grant the requester that was not granted last.
  - The last_grant flag resets to 1, so requester 0 wins the first contention.
  - last_grant updates on each grant.
- SETUP (1 cycle):
  - RIOT_A, RIOT_RS_N, RIOT_RW and RIOT_DIN are driven from the latched values.
  - RIOT_CS stays 2'b10, so no side effects occur.
  - Load the wait counter with WAIT_STATES.
- ACCESS (1 + WAIT_STATES cycles):
  - RIOT_CS = 2'b01.
  - Decrement the counter each cycle. Leave ACCESS when the counter is 0.
  - On the edge leaving ACCESS:
    - For a write, the RIOT commits the write.
    - For a read, capture RIOT_DOUT into RDATA.
  - A write leaves RDATA unchanged.
- DONE (1 cycle):
  - RIOT_CS = 2'b10 and RIOT_RW = 1.
  - ACKx = 1 for the granted requester only.
  - Next state is IDLE.
- After DONE, bus registers hold their values. Only RIOT_CS and RIOT_RW return to their idle values.
- A requester that keeps REQ high past ACK is treated as issuing a new request in the following IDLE cycle.
- Grant is fixed from IDLE through DONE. The other REQ is ignored until the next IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, last_grant = 1.
  - ACK0 = ACK1 = 0, RDATA = 8'h00, BUSY = 0.
  - RIOT_CS = 2'b10, RIOT_RS_N = 1, RIOT_A = 0, RIOT_RW = 1, RIOT_DIN = 0.
- Latency: REQ sampled high in IDLE at cycle 0 gives SETUP at cycle 1, ACCESS at cycles 2..2+WAIT_STATES, and ACK at cycle 3+WAIT_STATES.
  - A back-to-back access by the other requester reaches ACK 4+WAIT_STATES cycles after the first ACK.
- RIOT_CS is 2'b01 for exactly 1+WAIT_STATES consecutive cycles per access and never otherwise. This avoids spurious timer/IRQ-flag read side effects.
- RIOT_RW is 0 only during SETUP and ACCESS of a write.
- All outputs are registered; there is no combinational path from REQ to the RIOT pins.
- Reset asserted mid-access returns the FSM to IDLE immediately:
  - No ACK is issued.
  - A write whose committing edge has not occurred is dropped.
  - The requester must reissue the access.
- ADDR/WDATA changes while REQ is held are ignored after the grant.

## Test plan
- Reset, then requester 0 writes 8'h5A to ADDR 8'h10 (RAM), WAIT_STATES = 0 -> RIOT_CS = 01 at cycle 2 only, RIOT_RS_N = 0, RIOT_RW = 0, ACK0 at cycle 3. Follow-up read of 8'h10 -> RDATA = 8'h5A with ACK0.
- REQ0 and REQ1 rise in the same cycle after reset -> requester 0 granted first. Requester 1 is granted in the IDLE after DONE, with ACK1 4 cycles after ACK0. Repeated contention alternates grants.
- Requester 1 reads ADDR 8'h84 (timer) with WAIT_STATES = 3 -> CS = 01 for exactly 4 cycles, ACK1 at cycle 6, RDATA equals RIOT_DOUT sampled on the last ACCESS edge.
- Requester 0 holds REQ0 high across ACK0 while REQ1 stays low -> second access starts at the following IDLE. ACK0 pulses at cycles 3 and 7, never 2 cycles wide.
- RES_N pulled low during ACCESS of a write of 8'hFF to DDRA -> outputs return to reset values immediately, no ACK, DDRA is unchanged if reset precedes the committing edge.
- Idle for 20 cycles with no REQ -> RIOT_CS stays 10, BUSY = 0, RIOT_RW = 1 throughout.
